// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between instruction-fetch and data ports.
// Round-robin on conflict, registered handshake, optional wait-state abort.
module mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          ckl,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          err,
  output logic          busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IBUSY = 2'd1;
  localparam logic [1:0] DBUSY = 2'd2;
  localparam logic       GR_I  = 1'b0;
  localparam logic       GR_D  = 1'b1;
  localparam int         CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit         USE_TO = (TIMEOUT != 0);

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m_req_q, m_req_d, m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          i_ack_q, i_ack_d, d_ack_q, d_ack_d, err_q, err_d, busy_q, busy_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          i_elig, d_elig;

  // A port whose ack is high this cycle is still holding req; skip it once.
  assign i_elig = i_req & ~i_ack_q;
  assign d_elig = d_req & ~d_ack_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_elig && (!d_elig || last_q == GR_D)) begin
          state_d  = IBUSY;
          last_d   = GR_I;
          cnt_d    = '0;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = i_addr;
        end else if (d_elig) begin
          state_d   = DBUSY;
          last_d    = GR_D;
          cnt_d     = '0;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end
      end
      IBUSY, DBUSY: begin
        if (m_ready) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          if (state_q == IBUSY) begin
            i_ack_d   = 1'b1;
            i_rdata_d = m_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!m_we_q) d_rdata_d = m_rdata;
          end
        end else if (USE_TO && cnt_q == CNT_LAST) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          err_d   = 1'b1;
          if (state_q == IBUSY) begin
            i_ack_d   = 1'b1;
            i_rdata_d = '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ckl) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= GR_D;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ack   = i_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_rdata = d_rdata_q;
  assign err     = err_q;
  assign busy    = busy_q;
endmodule
